uart_tx_wb: RTL

Wishbone-slave UART transmitter with a transmit FIFO, attached to the core's data-bus slave fan-out as an additional peripheral window (next to mtime and debug). The core writes bytes to TXDATA. The block buffers them and serializes each one as 8N1 on `tx_o` at a programmable baud divisor. STATUS and CTRL registers give software polling and optional interrupt control.

---
 rtl/uart_tx_wb_if.sv | 24 ++
 rtl/uart_tx_wb.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_wb_if.sv
// Wishbone pipelined-slave signal bundle for uart_tx_wb.
// Signal names keep the slave-side _i/_o view so the peripheral reads naturally.
interface uart_tx_wb_if;
   logic        wb_cyc_i;
   logic        wb_stb_i;
   logic        wb_we_i;
   logic [31:0] wb_adr_i;
   logic [31:0] wb_dat_i;
   logic [3:0]  wb_sel_i;
   logic        wb_stall_o;
   logic        wb_ack_o;
   logic [31:0] wb_dat_o;
   logic        wb_err_o;

   modport slave (
      input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
      output wb_stall_o, wb_ack_o, wb_dat_o, wb_err_o
   );

   modport master (
      output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
      input  wb_stall_o, wb_ack_o, wb_dat_o, wb_err_o
   );
endinterface

// File: rtl/uart_tx_wb.sv
// Wishbone-slave 8N1 UART transmitter with TX FIFO and programmable baud divisor.
// Registers: 0x0 TXDATA, 0x4 STATUS, 0x8 BAUDDIV, 0xC CTRL.
// Optional feature macro: UART_TX_IRQ_EN enables the TX-empty interrupt and CTRL.IRQEN.
module uart_tx_wb #(
   parameter logic [31:0] BASE_ADR    = 32'h0000_8020,
   parameter int unsigned FIFO_DEPTH  = 8,
   parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,   // active-low, asynchronous
   uart_tx_wb_if.slave wb,
   output logic        tx_o,
   output logic        irq_o
);

   localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   // Bus decode
   logic       acc, bad, wr_ok, rd_ok, push_req, push, pop, full, empty, irqen;
   logic [1:0] off;

   // State
   state_e          state_q, state_d;
   logic [15:0]     timer_q, timer_d;
   logic [15:0]     per_q, per_d;
   logic [7:0]      shreg_q, shreg_d;
   logic [2:0]      bitcnt_q, bitcnt_d;
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] count_q, count_d;
   logic [7:0]      mem_q [FIFO_DEPTH];
   logic [15:0]     baud_q, baud_d;
   logic            txen_q, txen_d, ovf_q, ovf_d;
   logic            ack_q, ack_d, err_q, err_d;
   logic [31:0]     dat_q, dat_d;
   logic [31:0]     status, ctrl_rd;

   logic unused_bits;
   assign unused_bits = ^{BASE_ADR, wb.wb_adr_i[31:4], wb.wb_dat_i[31:16], wb.wb_sel_i[3:2]};

   assign acc      = wb.wb_cyc_i & wb.wb_stb_i;
   assign off      = wb.wb_adr_i[3:2];
   // Misaligned accesses and writes to STATUS are rejected without side effects
   assign bad      = (wb.wb_adr_i[1:0] != 2'b00) | (wb.wb_we_i & (off == 2'd1));
   assign wr_ok    = acc & ~bad & wb.wb_we_i;
   assign rd_ok    = acc & ~bad & ~wb.wb_we_i;
   assign push_req = wr_ok & (off == 2'd0) & wb.wb_sel_i[0];
   assign full     = (count_q == CntW'(FIFO_DEPTH));
   assign empty    = (count_q == '0);
   // Fullness uses the pre-pop count, so a push into a full FIFO is dropped
   assign push     = push_req & ~full;

   assign status  = {19'b0, 5'(count_q), 4'b0, ovf_q, (state_q != StIdle), full, empty};
   assign ctrl_rd = {29'b0, irqen, 1'b0, txen_q};

   assign wb.wb_stall_o = 1'b0;
   assign wb.wb_ack_o   = ack_q;
   assign wb.wb_err_o   = err_q;
   assign wb.wb_dat_o   = dat_q;

   // Register file writes, read mux and bus response
   always_comb begin
      baud_d = baud_q;
      txen_d = txen_q;
      ovf_d  = ovf_q;
      ack_d  = acc & ~bad;
      err_d  = acc & bad;
      dat_d  = '0;
      if (push_req && full) ovf_d = 1'b1;
      if (wr_ok) begin
         case (off)
            2'd2: begin
               if (wb.wb_sel_i[0]) baud_d[7:0]  = wb.wb_dat_i[7:0];
               if (wb.wb_sel_i[1]) baud_d[15:8] = wb.wb_dat_i[15:8];
            end
            2'd3: begin
               if (wb.wb_sel_i[0]) begin
                  txen_d = wb.wb_dat_i[0];
                  if (wb.wb_dat_i[1]) ovf_d = 1'b0;
               end
            end
            default: ;
         endcase
      end
      if (rd_ok) begin
         case (off)
            2'd1:    dat_d = status;
            2'd2:    dat_d = {16'b0, baud_q};
            2'd3:    dat_d = ctrl_rd;
            default: dat_d = '0;
         endcase
      end
   end

   // Transmit FSM: next state, bit timer, shifter and FIFO pop
   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q;
      per_d    = per_q;
      shreg_d  = shreg_q;
      bitcnt_d = bitcnt_q;
      pop      = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (txen_q && !empty) begin
               pop     = 1'b1;
               shreg_d = mem_q[rd_ptr_q];
               per_d   = baud_q;
               timer_d = baud_q;
               state_d = StStart;
            end
         end
         StStart: begin
            if (timer_q == '0) begin
               timer_d  = per_q;
               bitcnt_d = '0;
               state_d  = StData;
            end else begin
               timer_d = timer_q - 16'd1;
            end
         end
         StData: begin
            if (timer_q == '0) begin
               timer_d  = per_q;
               shreg_d  = shreg_q >> 1;
               bitcnt_d = bitcnt_q + 3'd1;
               if (bitcnt_q == 3'd7) state_d = StStop;
            end else begin
               timer_d = timer_q - 16'd1;
            end
         end
         StStop: begin
            if (timer_q == '0) state_d = StIdle;
            else               timer_d = timer_q - 16'd1;
         end
         default: state_d = StIdle;
      endcase
   end

   // FIFO pointer and occupancy update
   always_comb begin
      wr_ptr_d = wr_ptr_q + PtrW'(push);
      rd_ptr_d = rd_ptr_q + PtrW'(pop);
      count_d  = count_q;
      if (push && !pop)      count_d = count_q + CntW'(1);
      else if (!push && pop) count_d = count_q - CntW'(1);
   end

   // Serial line driven straight from state so reset forces idle-high at once
   always_comb begin
      tx_o = 1'b1;
      unique case (state_q)
         StStart: tx_o = 1'b0;
         StData:  tx_o = shreg_q[0];
         default: tx_o = 1'b1;
      endcase
   end

   // FIFO storage; contents are dropped logically by resetting the pointers
   always_ff @(posedge wb_clk_i) begin
      if (push) mem_q[wr_ptr_q] <= wb.wb_dat_i[7:0];
   end

   // State registers
   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i) begin
         state_q  <= StIdle;
         timer_q  <= '0;
         per_q    <= '0;
         shreg_q  <= '0;
         bitcnt_q <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         baud_q   <= DEFAULT_DIV;
         txen_q   <= 1'b1;
         ovf_q    <= 1'b0;
         ack_q    <= 1'b0;
         err_q    <= 1'b0;
         dat_q    <= '0;
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         per_q    <= per_d;
         shreg_q  <= shreg_d;
         bitcnt_q <= bitcnt_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         baud_q   <= baud_d;
         txen_q   <= txen_d;
         ovf_q    <= ovf_d;
         ack_q    <= ack_d;
         err_q    <= err_d;
         dat_q    <= dat_d;
      end
   end

`ifdef UART_TX_IRQ_EN
   logic irqen_q, irqen_d, irq_q, irq_d;

   assign irqen = irqen_q;
   assign irq_o = irq_q;

   // IRQEN write and registered TX-empty interrupt
   always_comb begin
      irqen_d = irqen_q;
      if (wr_ok && (off == 2'd3) && wb.wb_sel_i[0]) irqen_d = wb.wb_dat_i[2];
      irq_d = irqen_q & empty & (state_q == StIdle);
   end

   // Interrupt registers
   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i) begin
         irqen_q <= 1'b0;
         irq_q   <= 1'b0;
      end else begin
         irqen_q <= irqen_d;
         irq_q   <= irq_d;
      end
   end
`else
   assign irqen = 1'b0;
   assign irq_o = 1'b0;
`endif

endmodule
